// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard frame receiver with show-ahead scan-code FIFO
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   ps2_clk/ps2_dat raw PS/2 pad inputs (synchronised and debounced internally)
//   rd_en           pop strobe from an MMIO read of rd_data
//   clr_err         clears the sticky error flags
//   rd_data         {rx_valid, 23'b0, head scan code}, zero when empty
//   rx_valid        FIFO not empty
//   count           FIFO occupancy 0..2**FIFO_AW
//   parity_err      sticky: frame dropped for bad odd parity
//   frame_err       sticky: frame dropped for bad stop bit or mid-frame timeout
//   overflow        sticky: good frame dropped because the FIFO was full
module ps2_keyboard_rx #(
    parameter int FIFO_AW        = 4,
    parameter int DEBOUNCE       = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ps2_clk,
    input  logic               ps2_dat,
    input  logic               rd_en,
    input  logic               clr_err,
    output logic [31:0]        rd_data,
    output logic               rx_valid,
    output logic [FIFO_AW:0]   count,
    output logic               parity_err,
    output logic               frame_err,
    output logic               overflow
);
    localparam int DBW   = $clog2(DEBOUNCE + 1);
    localparam int WDW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic           clk_s1, clk_s2, dat_s1, dat_s2;
    logic           clk_db;
    logic [DBW-1:0] db_cnt;
    logic           fall;

    state_t         state, state_nx;
    logic [2:0]     bit_cnt;
    logic [7:0]     shreg;
    logic           par;
    logic [WDW-1:0] wd;
    logic           push, set_par, set_frm, timeout;

    logic [7:0]     mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic           empty, full, do_pop, do_push, set_ovf;

    // Two-flop synchronisers; idle bus is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

    // db_cnt counts consecutive samples that disagree with the debounced level;
    // the level flips on the DEBOUNCE-th one, any agreeing sample restarts the run.
    logic db_flip;
    assign db_flip = (clk_s2 != clk_db) && (db_cnt == DBW'(DEBOUNCE - 1));
    assign fall    = db_flip && clk_db;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_db <= 1'b1;
            db_cnt <= '0;
        end else if (clk_s2 == clk_db) begin
            db_cnt <= '0;
        end else if (db_flip) begin
            clk_db <= clk_s2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign timeout = (state != IDLE) && !fall && (wd == WDW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nx = state;
        push     = 1'b0;
        set_par  = 1'b0;
        set_frm  = 1'b0;
        case (state)
            IDLE:   if (fall && !dat_s2) state_nx = DATA;
            DATA:   if (fall && bit_cnt == 3'd7) state_nx = PARITY;
            PARITY: if (fall) state_nx = STOP;
            STOP: begin
                if (fall) begin
                    state_nx = IDLE;
                    if (!dat_s2)              set_frm = 1'b1;
                    else if (^{shreg, par})   push    = 1'b1;
                    else                      set_par = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (timeout) begin
            state_nx = IDLE;
            set_frm  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            wd      <= '0;
        end else begin
            state <= state_nx;
            if (fall) begin
                case (state)
                    IDLE:   bit_cnt <= '0;
                    DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY: par <= dat_s2;
                    default: ;
                endcase
            end
            // Watchdog measures the gap since the last fall while a frame is open.
            if (fall || state_nx == IDLE) wd <= '0;
            else                          wd <= wd + 1'b1;
        end
    end

    // Extra-MSB pointers: occupancy is the plain difference, full when it equals DEPTH.
    assign count    = wr_ptr - rd_ptr;
    assign empty    = (count == '0);
    assign full     = (count == {1'b1, {FIFO_AW{1'b0}}});
    assign do_pop   = rd_en && !empty;
    assign do_push  = push && (!full || do_pop);
    assign set_ovf  = push && full && !do_pop;
    assign rx_valid = !empty;
    assign rd_data  = empty ? 32'h0 : {1'b1, 23'b0, mem[rd_ptr[FIFO_AW-1:0]]};

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= shreg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (set_par)      parity_err <= 1'b1;
            else if (clr_err) parity_err <= 1'b0;
            if (set_frm)      frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
            if (set_ovf)      overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - directed self-checking bench for ps2_keyboard_rx
module tb_ps2_keyboard_rx;
    localparam int AW = 4;
    localparam int TO = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic        rd_en = 1'b0;
    logic        clr_err = 1'b0;
    logic [31:0] rd_data;
    logic        rx_valid;
    logic [AW:0] count;
    logic        parity_err, frame_err, overflow;

    int errors = 0;
    int checks = 0;

    ps2_keyboard_rx #(.FIFO_AW(AW), .DEBOUNCE(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .rd_en(rd_en), .clr_err(clr_err), .rd_data(rd_data), .rx_valid(rx_valid),
        .count(count), .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [7:0] d);
        return {1'b1, 23'b0, d};
    endfunction

    // One PS/2 bit: data set up in the high phase, then an 8-cycle low pulse.
    // With pop set, rd_en is raised in the cycle the fall is detected
    // (2 sync + 4 debounce cycles after the pad goes low), i.e. the push cycle.
    task automatic ps2_bit(input logic b, input bit pop);
        ps2_dat = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        if (pop) begin
            repeat (5) @(posedge clk);
            @(negedge clk) rd_en = 1'b1;
            @(negedge clk) rd_en = 1'b0;
            repeat (2) @(negedge clk);
        end else begin
            repeat (8) @(negedge clk);
        end
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit pop);
        ps2_bit(1'b0, 0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i], 0);
        ps2_bit(p, 0);
        ps2_bit(s, pop);
        ps2_dat = 1'b1;
    endtask

    task automatic good_frame(input logic [7:0] d);
        send_frame(d, ~^d, 1'b1, 0);
    endtask

    task automatic pop_one();
        @(negedge clk) rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
    endtask

    task automatic clear_errs();
        @(negedge clk) clr_err = 1'b1;
        @(negedge clk) clr_err = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_flags", {rx_valid, parity_err, frame_err, overflow}, 4'b0000);
        check("rst_count", count, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: single good frame, then pop
        send_frame(8'h1C, 1'b0, 1'b1, 0);
        check("t1_rd_data", rd_data, 32'h8000001C);
        check("t1_valid", rx_valid, 1'b1);
        check("t1_count", count, 1);
        pop_one();
        check("t1_pop_rd_data", rd_data, 32'h0);
        check("t1_pop_valid", rx_valid, 1'b0);

        // 2: bad parity, then bad stop
        send_frame(8'h1C, 1'b1, 1'b1, 0);
        check("t2_par_err", parity_err, 1'b1);
        check("t2_par_count", count, 0);
        clear_errs();
        check("t2_par_clr", parity_err, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 0);
        check("t2_frm_err", frame_err, 1'b1);
        check("t2_frm_par", parity_err, 1'b0);
        check("t2_frm_count", count, 0);
        clear_errs();
        check("t2_frm_clr", frame_err, 1'b0);

        // 3: overflow with 17 frames, ordered drain
        for (int i = 0; i < 17; i++) good_frame(8'(i));
        check("t3_count", count, 16);
        check("t3_overflow", overflow, 1'b1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t3_rd%0d", i), rd_data, word(8'(i)));
            pop_one();
        end
        check("t3_empty", {rx_valid, count}, 0);
        clear_errs();
        check("t3_ovf_clr", overflow, 1'b0);

        // 4: short glitch on ps2_clk while idle must be ignored
        @(negedge clk) ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        check("t4_count", count, 0);
        check("t4_errs", {parity_err, frame_err}, 2'b00);
        good_frame(8'h33);
        check("t4_after", rd_data, 32'h80000033);
        pop_one();

        // 5: partial frame then silence triggers the watchdog
        ps2_bit(1'b0, 0);
        ps2_bit(1'b1, 0);
        ps2_bit(1'b0, 0);
        ps2_bit(1'b1, 0);
        ps2_bit(1'b1, 0);
        ps2_dat = 1'b1;
        repeat (TO + 20) @(negedge clk);
        check("t5_frm_err", frame_err, 1'b1);
        check("t5_count", count, 0);
        clear_errs();
        good_frame(8'hF0);
        check("t5_after", rd_data, 32'h800000F0);
        check("t5_after_count", count, 1);
        check("t5_no_err", frame_err, 1'b0);
        pop_one();

        // 6: pop coinciding with a push while full
        for (int i = 0; i < 16; i++) good_frame(8'(8'h20 + i));
        check("t6_full", count, 16);
        send_frame(8'h30, ~^8'h30, 1'b1, 1);
        check("t6_count", count, 16);
        check("t6_no_ovf", overflow, 1'b0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t6_rd%0d", i), rd_data, word(8'(8'h21 + i)));
            pop_one();
        end

        // 6b: reset mid-frame clears FIFO and flags
        good_frame(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b1, 0);
        check("t6_pre_rst", {rx_valid, parity_err}, 2'b11);
        ps2_bit(1'b0, 0);
        ps2_bit(1'b1, 0);
        ps2_bit(1'b1, 0);
        ps2_dat = 1'b1;
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check("t6_rst_rd_data", rd_data, 32'h0);
        check("t6_rst_flags", {rx_valid, parity_err, frame_err, overflow}, 4'b0000);
        check("t6_rst_count", count, 0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        good_frame(8'h66);
        check("t6_post_rd", rd_data, 32'h80000066);
        check("t6_post_count", count, 1);
        check("t6_post_errs", {parity_err, frame_err, overflow}, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
